// File: rtl/run_controller.sv
// Run-control sequencer: start/hold/load/run/done FSM that drives the PC load and gates execution.
// Optional single-step mode is enabled by defining RUN_CTRL_STEP_EN (adds step_mode/step inputs).
module run_controller #(
  parameter int CYCLE_W    = 16,
  parameter int MAX_CYCLES = 4096,
  parameter int PC_W       = 32,
  parameter int SLOTS      = 4,
  parameter int SLOT_SHIFT = 8,
  localparam int SEL_W     = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [SEL_W-1:0]   prog_sel,
  input  logic               halt_req,
`ifdef RUN_CTRL_STEP_EN
  input  logic               step_mode,
  input  logic               step,
`endif
  output logic               run_en,
  output logic               pc_load,
  output logic [PC_W-1:0]    pc_load_value,
  output logic               done,
  output logic               timeout,
  output logic [CYCLE_W-1:0] cycle_count
);

  typedef enum logic [2:0] {S_IDLE, S_HOLD, S_LOAD, S_RUN, S_DONE} state_e;

  state_e             state_q, state_d;
  logic               run_en_q, run_en_d;
  logic               pc_load_q, pc_load_d;
  logic [PC_W-1:0]    pc_load_value_q, pc_load_value_d;
  logic               done_q, done_d;
  logic               timeout_q, timeout_d;
  logic [CYCLE_W-1:0] cycle_count_q, cycle_count_d;

  logic               exec;
  logic               budget_hit;
  logic               run_gate;
  logic [PC_W-1:0]    slot_base;

  // An instruction executed in the cycle just ending only if run_en was high in RUN.
  assign exec       = (state_q == S_RUN) && run_en_q;
  assign budget_hit = (cycle_count_q == CYCLE_W'(MAX_CYCLES - 1));
  assign slot_base  = PC_W'(prog_sel) << SLOT_SHIFT;

`ifdef RUN_CTRL_STEP_EN
  assign run_gate = step_mode ? step : 1'b1;
`else
  assign run_gate = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_IDLE;
      run_en_q        <= 1'b0;
      pc_load_q       <= 1'b0;
      pc_load_value_q <= '0;
      done_q          <= 1'b0;
      timeout_q       <= 1'b0;
      cycle_count_q   <= '0;
    end else begin
      state_q         <= state_d;
      run_en_q        <= run_en_d;
      pc_load_q       <= pc_load_d;
      pc_load_value_q <= pc_load_value_d;
      done_q          <= done_d;
      timeout_q       <= timeout_d;
      cycle_count_q   <= cycle_count_d;
    end
  end

  // A start level in LOAD or RUN aborts back to HOLD ahead of any halt or budget event.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_HOLD;
      S_HOLD: if (!start) state_d = S_LOAD;
      S_LOAD: state_d = start ? S_HOLD : S_RUN;
      S_RUN: begin
        if (start)                          state_d = S_HOLD;
        else if (exec && (halt_req || budget_hit)) state_d = S_DONE;
      end
      S_DONE: if (start) state_d = S_HOLD;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    run_en_d        = 1'b0;
    pc_load_d       = 1'b0;
    pc_load_value_d = pc_load_value_q;
    done_d          = done_q;
    timeout_d       = timeout_q;
    cycle_count_d   = cycle_count_q;
    if (state_q == S_HOLD) pc_load_value_d = slot_base;
    if (exec) cycle_count_d = cycle_count_q + CYCLE_W'(1);
    case (state_d)
      S_HOLD: begin
        cycle_count_d = '0;
        done_d        = 1'b0;
        timeout_d     = 1'b0;
      end
      S_LOAD: pc_load_d = 1'b1;
      S_RUN:  run_en_d  = run_gate;
      S_DONE: begin
        done_d = 1'b1;
        // Halt has priority over budget exhaustion on the same cycle.
        if (state_q == S_RUN) timeout_d = ~halt_req;
      end
      default: ;
    endcase
  end

  assign run_en        = run_en_q;
  assign pc_load       = pc_load_q;
  assign pc_load_value = pc_load_value_q;
  assign done          = done_q;
  assign timeout       = timeout_q;
  assign cycle_count   = cycle_count_q;

endmodule

// File: tb/tb_run_controller.sv
// Directed bench for run_controller: vector table plus hand sequences for timeout, abort, reset and step mode.
module tb_run_controller;
  localparam int CYCLE_W    = 16;
  localparam int MAX_CYCLES = 16;
  localparam int PC_W       = 32;
  localparam int SLOTS      = 4;
  localparam int SLOT_SHIFT = 8;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               start = 1'b0;
  logic [1:0]         prog_sel = 2'd0;
  logic               halt_req = 1'b0;
`ifdef RUN_CTRL_STEP_EN
  logic               step_mode = 1'b0;
  logic               step = 1'b0;
`endif
  logic               run_en, pc_load, done, timeout;
  logic [PC_W-1:0]    pc_load_value;
  logic [CYCLE_W-1:0] cycle_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  run_controller #(
    .CYCLE_W(CYCLE_W), .MAX_CYCLES(MAX_CYCLES), .PC_W(PC_W),
    .SLOTS(SLOTS), .SLOT_SHIFT(SLOT_SHIFT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .prog_sel(prog_sel),
    .halt_req(halt_req),
`ifdef RUN_CTRL_STEP_EN
    .step_mode(step_mode),
    .step(step),
`endif
    .run_en(run_en),
    .pc_load(pc_load),
    .pc_load_value(pc_load_value),
    .done(done),
    .timeout(timeout),
    .cycle_count(cycle_count)
  );

  typedef struct {
    logic        rst;
    logic        st;
    logic [1:0]  sel;
    logic        halt;
    logic        e_run;
    logic        e_load;
    logic [31:0] e_pcv;
    logic        e_done;
    logic        e_to;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic rst, input logic st, input logic [1:0] sel,
                              input logic halt, input logic e_run, input logic e_load,
                              input logic [31:0] e_pcv, input logic e_done, input logic e_to,
                              input logic [15:0] e_cnt);
    vec_t v;
    v.rst = rst; v.st = st; v.sel = sel; v.halt = halt;
    v.e_run = e_run; v.e_load = e_load; v.e_pcv = e_pcv;
    v.e_done = e_done; v.e_to = e_to; v.e_cnt = e_cnt;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string tag, input logic e_run, input logic e_load,
                         input logic [31:0] e_pcv, input logic e_done, input logic e_to,
                         input logic [15:0] e_cnt);
    chk({tag, ".run_en"},        {31'd0, run_en},      {31'd0, e_run});
    chk({tag, ".pc_load"},       {31'd0, pc_load},     {31'd0, e_load});
    chk({tag, ".pc_load_value"}, pc_load_value,        e_pcv);
    chk({tag, ".done"},          {31'd0, done},        {31'd0, e_done});
    chk({tag, ".timeout"},       {31'd0, timeout},     {31'd0, e_to});
    chk({tag, ".cycle_count"},   {16'd0, cycle_count}, {16'd0, e_cnt});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int runs;
    logic done_seen;

    // Load sequence, halt on the 10th RUN cycle, hold in DONE, restart into slot 1.
    add(1, 0, 0, 0,  0, 0, 32'h000, 0, 0, 0);
    add(0, 0, 0, 0,  0, 0, 32'h000, 0, 0, 0);
    add(0, 1, 2, 0,  0, 0, 32'h000, 0, 0, 0);
    add(0, 1, 2, 0,  0, 0, 32'h200, 0, 0, 0);
    add(0, 1, 2, 0,  0, 0, 32'h200, 0, 0, 0);
    add(0, 0, 2, 0,  0, 1, 32'h200, 0, 0, 0);
    add(0, 0, 3, 0,  1, 0, 32'h200, 0, 0, 0);
    for (int k = 1; k <= 9; k++) add(0, 0, 3, 0, 1, 0, 32'h200, 0, 0, 16'(k));
    add(0, 0, 3, 1,  0, 0, 32'h200, 1, 0, 10);
    add(0, 0, 1, 1,  0, 0, 32'h200, 1, 0, 10);
    add(0, 0, 1, 1,  0, 0, 32'h200, 1, 0, 10);
    add(0, 1, 1, 0,  0, 0, 32'h200, 0, 0, 0);
    add(0, 1, 1, 0,  0, 0, 32'h100, 0, 0, 0);
    add(0, 0, 1, 0,  0, 1, 32'h100, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      reset = tbl[i].rst; start = tbl[i].st; prog_sel = tbl[i].sel; halt_req = tbl[i].halt;
      tick();
      chk_out($sformatf("vec%0d", i), tbl[i].e_run, tbl[i].e_load, tbl[i].e_pcv,
              tbl[i].e_done, tbl[i].e_to, tbl[i].e_cnt);
    end
    halt_req = 1'b0;

    // Budget exhaustion: run_en high for exactly MAX_CYCLES cycles.
    runs = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      tick();
      if (run_en) runs++;
    end
    chk("timeout.runs", runs, MAX_CYCLES);
    chk_out("timeout", 0, 0, 32'h100, 1, 1, 16);

    // Halt coincident with the last budget cycle: halt wins.
    start = 1'b1; tick();
    chk_out("coinc.hold", 0, 0, 32'h100, 0, 0, 0);
    start = 1'b0; prog_sel = 2'd0; tick();
    chk_out("coinc.load", 0, 1, 32'h000, 0, 0, 0);
    tick();
    for (int i = 1; i <= 15; i++) tick();
    chk_out("coinc.pre", 1, 0, 32'h000, 0, 0, 15);
    halt_req = 1'b1; tick(); halt_req = 1'b0;
    chk_out("coinc.done", 0, 0, 32'h000, 1, 0, 16);

    // Abort in RUN at cycle 5, restart with slot 1, then reset mid-run.
    done_seen = 1'b0;
    start = 1'b1; tick();
    start = 1'b0; tick();
    tick();
    for (int i = 0; i < 5; i++) begin tick(); done_seen |= done; end
    chk_out("abort.pre", 1, 0, 32'h000, 0, 0, 5);
    start = 1'b1; tick(); done_seen |= done;
    chk_out("abort.hold", 0, 0, 32'h000, 0, 0, 0);
    prog_sel = 2'd1; tick(); done_seen |= done;
    start = 1'b0; tick(); done_seen |= done;
    chk_out("abort.load", 0, 1, 32'h100, 0, 0, 0);
    prog_sel = 2'd2;
    for (int i = 0; i < 4; i++) begin tick(); done_seen |= done; end
    chk_out("abort.run", 1, 0, 32'h100, 0, 0, 3);
    chk("abort.done_seen", {31'd0, done_seen}, 32'd0);
    reset = 1'b1; tick();
    chk_out("midreset", 0, 0, 32'h000, 0, 0, 0);
    reset = 1'b0; tick();

`ifdef RUN_CTRL_STEP_EN
    // Single-step: three non-adjacent steps, halt on the third; halt while not stepping is ignored.
    step_mode = 1'b1; step = 1'b0; prog_sel = 2'd3;
    start = 1'b1; tick();
    start = 1'b0; tick();
    chk_out("step.load", 0, 1, 32'h300, 0, 0, 0);
    tick();
    chk_out("step.idle", 0, 0, 32'h300, 0, 0, 0);
    halt_req = 1'b1; tick(); halt_req = 1'b0;
    chk_out("step.ign0", 0, 0, 32'h300, 0, 0, 0);
    step = 1'b1; tick(); step = 1'b0;
    chk_out("step.s1", 1, 0, 32'h300, 0, 0, 0);
    tick();
    tick();
    chk_out("step.c1", 0, 0, 32'h300, 0, 0, 1);
    step = 1'b1; tick(); step = 1'b0;
    tick();
    halt_req = 1'b1; tick(); halt_req = 1'b0;
    chk_out("step.ign1", 0, 0, 32'h300, 0, 0, 2);
    step = 1'b1; tick(); step = 1'b0;
    chk_out("step.s3", 1, 0, 32'h300, 0, 0, 2);
    halt_req = 1'b1; tick(); halt_req = 1'b0;
    chk_out("step.done", 0, 0, 32'h300, 1, 0, 3);
    step_mode = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
